// File: rtl/booth_pkg.sv
// Shared Booth radix-4 types and helpers for the multiplier stages.
// Optional split-negative row form selected by BOOTH_SPLIT_NEG_EN (see booth_pp_streamer).
package booth_pkg;

    typedef enum logic [2:0] {ZERO, P1, P2, M1, M2} booth_digit_t;

    typedef enum logic {IDLE, EMIT} pp_state_t;

    function automatic int rows(input int width);
        return width / 2;
    endfunction

    // Triplet is {b[2i+1], b[2i], b[2i-1]}; 000 and 111 both decode to ZERO.
    function automatic booth_digit_t booth_decode(input logic [2:0] triplet);
        booth_digit_t digit;
        case (triplet)
            3'b001, 3'b010: digit = P1;
            3'b011:         digit = P2;
            3'b100:         digit = M2;
            3'b101, 3'b110: digit = M1;
            default:        digit = ZERO;
        endcase
        return digit;
    endfunction

endpackage

// File: rtl/booth_digit_enc.sv
// Combinational Booth digit encoder: triplet -> {zero, two, neg}.
module booth_digit_enc
    import booth_pkg::*;
(
    input  logic [2:0] triplet,
    output logic       zero,
    output logic       two,
    output logic       neg
);

    booth_digit_t digit;

    always_comb begin
        digit = booth_decode(triplet);
        zero  = (digit == ZERO);
        two   = (digit == P2) || (digit == M2);
        neg   = (digit == M1) || (digit == M2);
    end

endmodule

// File: rtl/booth_pp_streamer.sv
// Radix-4 Booth partial-product streamer: one operand pair in, WIDTH/2 rows out.
// Define BOOTH_SPLIT_NEG_EN for one's-complement negative rows with pp_neg as the +1 carry-in.
module booth_pp_streamer
    import booth_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    output logic                       pp_valid,
    input  logic                       pp_ready,
    output logic [2*WIDTH-1:0]         pp_row,
    output logic [$clog2(WIDTH/2)-1:0] pp_idx,
    output logic                       pp_neg,
    output logic                       pp_last
);

    localparam int ROWS  = rows(WIDTH);
    localparam int IDX_W = $clog2(ROWS);
    localparam int PW    = 2 * WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

    pp_state_t        state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [PW-1:0]    row_q, row_d;
    logic             neg_q, neg_d;
    logic             last_q, last_d;

    logic             from_bus;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [IDX_W-1:0] src_idx;
    logic [IDX_W:0]   shamt;
    logic [WIDTH:0]   b_ext;
    logic [2:0]       triplet;
    logic             dig_zero;
    logic             dig_two;
    logic             dig_neg;
    logic [PW-1:0]    a_ext;
    logic [PW-1:0]    mag;
    logic [PW-1:0]    shifted;
    logic [PW-1:0]    row_form;

    booth_digit_enc u_enc (
        .triplet (triplet),
        .zero    (dig_zero),
        .two     (dig_two),
        .neg     (dig_neg)
    );

    // Single row former: in IDLE it builds row 0 straight from the input bus so
    // the row is registered on the accept edge; in EMIT it builds row idx+1.
    always_comb begin
        from_bus = (state_q == IDLE);
        src_a    = from_bus ? in_a : a_q;
        src_b    = from_bus ? in_b : b_q;
        src_idx  = from_bus ? '0 : idx_q + IDX_W'(1);
        shamt    = {src_idx, 1'b0};
        b_ext    = {src_b, 1'b0};
        triplet  = 3'(b_ext >> shamt);
        a_ext    = {{WIDTH{src_a[WIDTH-1]}}, src_a};
        mag      = dig_zero ? '0 : (dig_two ? (a_ext << 1) : a_ext);
        shifted  = mag << shamt;
`ifdef BOOTH_SPLIT_NEG_EN
        row_form = dig_neg ? (~shifted & ({PW{1'b1}} << shamt)) : shifted;
`else
        row_form = dig_neg ? (~shifted + PW'(1)) : shifted;
`endif
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        row_d   = row_q;
        neg_d   = neg_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = EMIT;
                    a_d     = in_a;
                    b_d     = in_b;
                    idx_d   = '0;
                    row_d   = row_form;
                    neg_d   = dig_neg;
                    last_d  = (src_idx == LAST_IDX);
                end
            end
            EMIT: begin
                if (pp_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        row_d   = '0;
                        neg_d   = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        idx_d   = src_idx;
                        row_d   = row_form;
                        neg_d   = dig_neg;
                        last_d  = (src_idx == LAST_IDX);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            row_q   <= '0;
            neg_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            row_q   <= row_d;
            neg_q   <= neg_d;
            last_q  <= last_d;
        end
    end

    assign in_ready = (state_q == IDLE) && !rst;
    assign pp_valid = (state_q == EMIT);
    assign pp_row   = row_q;
    assign pp_idx   = idx_q;
    assign pp_neg   = neg_q;
    assign pp_last  = last_q;

endmodule

// File: tb/tb_booth_pp_streamer.sv
// Scoreboard bench for booth_pp_streamer (WIDTH=16); tracks BOOTH_SPLIT_NEG_EN like the RTL.
`timescale 1ns/1ps
module tb_booth_pp_streamer;

    localparam int W  = 16;
    localparam int R  = W / 2;
    localparam int IW = $clog2(R);

    typedef struct packed {
        logic [2*W-1:0] row;
        logic [IW-1:0]  idx;
        logic           neg;
        logic           last;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           pp_valid;
    logic           pp_ready;
    logic [2*W-1:0] pp_row;
    logic [IW-1:0]  pp_idx;
    logic           pp_neg;
    logic           pp_last;

    int             n_tests = 0;
    int             n_fail  = 0;
    exp_t           exp_q[$];
    logic [2*W-1:0] prod_q[$];
    logic [2*W-1:0] acc = '0;
    logic [2*W-1:0] last_sum = '0;
    logic           rand_ready = 1'b0;
    exp_t           mon_e;

    always #5 clk = ~clk;

    booth_pp_streamer #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .pp_valid (pp_valid),
        .pp_ready (pp_ready),
        .pp_row   (pp_row),
        .pp_idx   (pp_idx),
        .pp_neg   (pp_neg),
        .pp_last  (pp_last)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference rows from the arithmetic digit formula d = -2*b[2i+1] + b[2i] + b[2i-1].
    task automatic push_expected(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0]     bx;
        longint         av;
        longint         mag;
        int             d;
        logic [2*W-1:0] sh;
        logic [2*W-1:0] rowv;
        exp_t           e;
        bx = {b, 1'b0};
        av = longint'($signed(a));
        for (int i = 0; i < R; i++) begin
            d = -2 * int'(bx[2*i+2]) + int'(bx[2*i+1]) + int'(bx[2*i]);
`ifdef BOOTH_SPLIT_NEG_EN
            if (d < 0) begin
                mag  = longint'(-d) * av;
                sh   = 32'(mag << (2*i));
                rowv = ~sh & (32'hFFFF_FFFF << (2*i));
            end else begin
                rowv = 32'((longint'(d) * av) << (2*i));
            end
`else
            mag  = longint'(d) * av;
            rowv = 32'(mag << (2*i));
`endif
            e.row  = rowv;
            e.idx  = IW'(i);
            e.neg  = (d < 0);
            e.last = (i == R - 1);
            exp_q.push_back(e);
        end
        prod_q.push_back(32'(av * longint'($signed(b))));
    endtask

    // Monitor: compares every accepted row and the per-operation product.
    always begin
        @(negedge clk);
        #1;
        if (!rst && pp_valid && pp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_row", {32'd0, pp_row}, 64'hDEAD);
            end else begin
                mon_e = exp_q.pop_front();
                check("pp_row", {32'd0, pp_row}, {32'd0, mon_e.row});
                check("pp_idx", {61'd0, pp_idx}, {61'd0, mon_e.idx});
                check("pp_neg", {63'd0, pp_neg}, {63'd0, mon_e.neg});
                check("pp_last", {63'd0, pp_last}, {63'd0, mon_e.last});
`ifdef BOOTH_SPLIT_NEG_EN
                acc = acc + pp_row + (pp_neg ? (32'd1 << (2*int'(mon_e.idx))) : 32'd0);
`else
                acc = acc + pp_row;
`endif
                if (mon_e.last) begin
                    last_sum = acc;
                    acc = '0;
                    if (prod_q.size() != 0) begin
                        check("product", {32'd0, last_sum}, {32'd0, prod_q.pop_front()});
                    end else begin
                        check("product_missing", 64'd1, 64'd0);
                    end
                    $display("[TB] op done sum=%08h", last_sum);
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("send_timeout", {63'd0, in_ready}, 64'd1);
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        push_expected(a, b);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while ((exp_q.size() != 0 || !in_ready) && t < 400) begin
            @(negedge clk);
            if (rand_ready) pp_ready = ($urandom_range(0, 3) != 0);
            t++;
        end
        if (exp_q.size() != 0 || !in_ready) begin
            check("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
            prod_q.delete();
            acc = '0;
        end
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [W-1:0]   corner_a [5] = '{16'h8000, 16'h8000, 16'h0000, 16'hFFFF, 16'h5555};
    logic [W-1:0]   corner_b [5] = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'hFFFF, 16'hAAAA};

    initial begin : stimulus
        int             n;
        int             t;
        logic [2*W-1:0] hold_row;
        logic [IW-1:0]  hold_idx;
        logic           hold_neg;
        logic           hold_last;

        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        pp_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check("rst_pp_valid", {63'd0, pp_valid}, 64'd0);
        check("rst_pp_row", {32'd0, pp_row}, 64'd0);
        check("rst_pp_idx", {61'd0, pp_idx}, 64'd0);
        check("rst_pp_neg", {63'd0, pp_neg}, 64'd0);
        check("rst_pp_last", {63'd0, pp_last}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

        // A=3, B=5: in_ready must come back on the 9th negedge after the accept.
        @(negedge clk);
        in_a = 16'd3;
        in_b = 16'd5;
        in_valid = 1'b1;
        push_expected(16'd3, 16'd5);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_return_cycles", 64'(n), 64'(R + 1));
        wait_done();
        check("sum_3x5", {32'd0, last_sum}, 64'h0000_000F);

        send(16'hFFFF, 16'h8000);
        wait_done();
        check("sum_m1x8000", {32'd0, last_sum}, 64'h0000_8000);

        send(16'h7FFF, 16'h7FFF);
        wait_done();
        check("sum_7fff_sq", {32'd0, last_sum}, 64'h3FFF_0001);

        // Backpressure: stall three edges on idx 2.
        pp_ready = 1'b0;
        send(16'h1234, 16'hB6D5);
        pp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        pp_ready = 1'b0;
        #2;
        check("stall_idx", {61'd0, pp_idx}, 64'd2);
        hold_row  = pp_row;
        hold_idx  = pp_idx;
        hold_neg  = pp_neg;
        hold_last = pp_last;
        repeat (3) begin
            @(negedge clk);
            #2;
            check("stall_valid", {63'd0, pp_valid}, 64'd1);
            check("stall_row", {32'd0, pp_row}, {32'd0, hold_row});
            check("stall_idx_hold", {61'd0, pp_idx}, {61'd0, hold_idx});
            check("stall_neg", {63'd0, pp_neg}, {63'd0, hold_neg});
            check("stall_last", {63'd0, pp_last}, {63'd0, hold_last});
        end
        @(negedge clk);
        pp_ready = 1'b1;
        @(negedge clk);
        #2;
        check("after_stall_idx", {61'd0, pp_idx}, 64'd3);
        wait_done();

        // Reset during idx 3 aborts the operation.
        send(16'h1357, 16'hACE1);
        t = 0;
        while (pp_idx != 3 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("reach_idx3", {61'd0, pp_idx}, 64'd3);
        #2;
        rst = 1'b1;
        @(negedge clk);
        #2;
        check("abort_pp_valid", {63'd0, pp_valid}, 64'd0);
        check("abort_pp_row", {32'd0, pp_row}, 64'd0);
        check("abort_pp_idx", {61'd0, pp_idx}, 64'd0);
        check("abort_pp_neg", {63'd0, pp_neg}, 64'd0);
        check("abort_pp_last", {63'd0, pp_last}, 64'd0);
        check("abort_in_ready", {63'd0, in_ready}, 64'd0);
        rst = 1'b0;
        #1;
        check("abort_ready_after", {63'd0, in_ready}, 64'd1);
        exp_q.delete();
        prod_q.delete();
        acc = '0;
        send(16'hF00D, 16'h0F0F);
        wait_done();

        // in_valid held with new operands during EMIT must not be captured early.
        @(negedge clk);
        in_a = 16'h2468;
        in_b = 16'h9ABC;
        in_valid = 1'b1;
        push_expected(16'h2468, 16'h9ABC);
        @(negedge clk);
        in_a = 16'hC001;
        in_b = 16'h0033;
        push_expected(16'hC001, 16'h0033);
        n = 1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reaccept_cycles", 64'(n), 64'(R + 1));
        @(negedge clk);
        in_valid = 1'b0;
        wait_done();

        for (int i = 0; i < 5; i++) begin
            send(corner_a[i], corner_b[i]);
            wait_done();
        end

        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            send(16'($urandom), 16'($urandom));
            wait_done();
        end
        rand_ready = 1'b0;
        pp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
